// File: rtl/ece369_pipe_pkg.sv
// ece369_pipe_pkg: shared state encoding and ID/EX payload layout for the pipeline stage registers
package ece369_pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  localparam int PC4_W = 32;
  localparam int RD1_W = 32;
  localparam int RD2_W = 32;
  localparam int IMM_W = 32;
  localparam int REG_W = 5;
  localparam int RD_LSB = 0;
  localparam int RT_LSB = 5;
  localparam int IMM_LSB = 10;
  localparam int RD2_LSB = 42;
  localparam int RD1_LSB = 74;
  localparam int PC4_LSB = 106;
  localparam int IDEX_DATA_W = 138;
  localparam int IDEX_CTRL_W = 16;
  // ALUOp is 5 bits wide so the word fits 16 bits with Load_size at 15:14
  localparam int C_REG_WRITE = 0;
  localparam int C_MEM_TO_REG = 1;
  localparam int C_BRANCH = 2;
  localparam int C_MEM_READ = 3;
  localparam int C_MEM_WRITE = 4;
  localparam int C_REG_DST = 5;
  localparam int C_ALU_OP_LSB = 6;
  localparam int C_ALU_OP_W = 5;
  localparam int C_ALU_SRC = 11;
  localparam int C_STORE_SIZE_LSB = 12;
  localparam int C_LOAD_SIZE_LSB = 14;
  function automatic logic [IDEX_DATA_W-1:0] idex_pack(input logic [PC4_W-1:0] pc4,
    input logic [RD1_W-1:0] rd1, input logic [RD2_W-1:0] rd2, input logic [IMM_W-1:0] imm,
    input logic [REG_W-1:0] rt, input logic [REG_W-1:0] rd);
    return {pc4, rd1, rd2, imm, rt, rd};
  endfunction
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream handshake, flush and stall counter of one stage
interface pipe_stage_reg_if #(parameter int DATA_W = 138, parameter int CTRL_W = 16, parameter int CNT_W = 16);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0] stall_cnt;
  modport master(output flush, in_valid, in_data, in_ctrl, out_ready,
                 input in_ready, out_valid, out_data, out_ctrl, stall_cnt);
  modport slave(input flush, in_valid, in_data, in_ctrl, out_ready,
                output in_ready, out_valid, out_data, out_ctrl, stall_cnt);
endinterface

// File: rtl/pipe_slot.sv
// pipe_slot: one data+ctrl entry register; clr_ctrl zeroes ctrl and leaves data untouched
module pipe_slot #(parameter int DATA_W = 138, parameter int CTRL_W = 16) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr_ctrl,
  input  logic [DATA_W-1:0] d,
  input  logic [CTRL_W-1:0] c,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data <= '0;
      ctrl <= '0;
    end else begin
      data <= load ? d : data;
      ctrl <= clr_ctrl ? '0 : load ? c : ctrl;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic two-entry skid stage register with flush and saturating stall counter
module pipe_stage_reg
  import ece369_pipe_pkg::*;
#(
  parameter int DATA_W = IDEX_DATA_W,
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter int CNT_W = 16
) (
  input logic Clk,
  input logic Rst_n,
  pipe_stage_reg_if.slave bus
);
  state_t state, nxt;
  logic in_ready, out_valid, in_fire, out_fire, load_main, load_skid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [CNT_W-1:0] cnt;
  assign in_ready = state != TWO;
  assign out_valid = state != EMPTY;
  assign in_fire = bus.in_valid & in_ready;
  assign out_fire = out_valid & bus.out_ready;
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data = main_data;
  assign bus.out_ctrl = out_valid ? main_ctrl : '0;
  assign bus.stall_cnt = cnt;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) state <= EMPTY;
    else state <= nxt;
  always_comb begin
    nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    if (bus.flush) nxt = EMPTY;
    else
      case (state)
        EMPTY: begin
          nxt = in_fire ? ONE : EMPTY;
          load_main = in_fire;
        end
        ONE: begin
          nxt = (in_fire & !out_fire) ? TWO : (!in_fire & out_fire) ? EMPTY : ONE;
          load_main = in_fire & out_fire;
          load_skid = in_fire & !out_fire;
        end
        TWO: begin
          nxt = out_fire ? ONE : TWO;
          load_main = out_fire;
        end
        default: nxt = EMPTY;
      endcase
  end
  // in TWO the main register refills from skid, otherwise straight from upstream
  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk(Clk), .rst_n(Rst_n), .load(load_main), .clr_ctrl(bus.flush),
    .d(state == TWO ? skid_data : bus.in_data), .c(state == TWO ? skid_ctrl : bus.in_ctrl),
    .data(main_data), .ctrl(main_ctrl)
  );
  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk(Clk), .rst_n(Rst_n), .load(load_skid), .clr_ctrl(bus.flush),
    .d(bus.in_data), .c(bus.in_ctrl), .data(skid_data), .ctrl(skid_ctrl)
  );
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) cnt <= '0;
    else if (out_valid & !bus.out_ready & (cnt != '1)) cnt <= cnt + 1'b1;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench; the queue models stage contents, occupancy and stall count
module tb_pipe_stage_reg;
  localparam int DW = 138;
  localparam int CW = 16;
  localparam int NW = 4;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int scnt = 0;
  logic [DW+CW-1:0] q[$];
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) bus ();
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus.slave));
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic r, input logic f);
    logic ev, er;
    bus.in_valid = v;
    bus.in_data = d;
    bus.in_ctrl = c;
    bus.out_ready = r;
    bus.flush = f;
    #1;
    ev = q.size() != 0;
    er = q.size() < 2;
    chk("out_valid", bus.out_valid, ev);
    chk("in_ready", bus.in_ready, er);
    chk("stall_cnt", bus.stall_cnt, scnt);
    if (ev) begin
      chk("out_data", bus.out_data, q[0][DW+CW-1:CW]);
      chk("out_ctrl", bus.out_ctrl, q[0][CW-1:0]);
    end else chk("bubble_ctrl", bus.out_ctrl, 0);
    if (ev && !r && scnt != 15) scnt++;
    if (ev && r) void'(q.pop_front());
    if (f) q.delete();
    else if (v && er) q.push_back({d, c});
    @(posedge Clk);
    @(negedge Clk);
  endtask
  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    Rst_n = 1'b0;
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_ctrl", bus.out_ctrl, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_cnt", bus.stall_cnt, 0);
    q.delete();
    scnt = 0;
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_ctrl = '0;
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
    repeat (2) @(negedge Clk);
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), CW'(16'h100 + i), 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b1, DW'(8'hA), 16'h00A1, 1'b0, 1'b0);
    step(1'b1, DW'(8'hB), 16'h00B1, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b1, DW'(8'hA), 16'h0A0A, 1'b0, 1'b0);
    step(1'b1, DW'(8'hB), 16'h0B0B, 1'b0, 1'b0);
    step(1'b1, DW'(8'hC), 16'h0C0C, 1'b0, 1'b1);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b1, DW'(8'h5A), 16'hFFFF, 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b1, ece369_pipe_pkg::idex_pack(32'h4, 32'h11, 32'h22, 32'h33, 5'd7, 5'd9), 16'hC3A5, 1'b0, 1'b0);
    step(1'b1, DW'(8'h77), 16'h7777, 1'b0, 1'b0);
    do_reset();
    step(1'b1, DW'(8'h55), 16'h5555, 1'b0, 1'b0);
    repeat (20) step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("sat_cnt", bus.stall_cnt, 15);
    repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 120; i++)
      step(1'($urandom % 2), DW'({$urandom, $urandom, $urandom, $urandom, $urandom}), CW'($urandom),
           1'($urandom % 4 != 0), 1'($urandom % 16 == 0));
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
